// File: rtl/pc_sequencer.sv
// Next-PC controller for fetch: arbitrates exception / mispredict / predictor /
// sequential redirects, holds PC under stall and parks a stalled mispredict.
module pc_sequencer #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 'hBFC00000,
  parameter int                    INST_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  exc_valid,
  input  logic [ADDR_WIDTH-1:0] exc_pc,
  input  logic                  bra_valid,
  input  logic [ADDR_WIDTH-1:0] bra_pc,
  input  logic                  pred_valid,
  input  logic [ADDR_WIDTH-1:0] pred_pc,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  pc_valid,
  output logic                  flush_out,
  output logic                  redirect_pending
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  state_t                state;
  logic                  pending;
  logic                  pend_is_exc;
  logic [ADDR_WIDTH-1:0] pend_pc;

  // Flush fires even while stalled so the buffer drops its wrong-path PC.
  assign flush_out        = ~rst & (exc_valid | bra_valid);
  assign redirect_pending = pending | pend_is_exc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      pc_valid    <= 1'b0;
      pending     <= 1'b0;
      pend_pc     <= '0;
      pend_is_exc <= 1'b0;
    end else begin
      unique case (state)
        BOOT: begin
          // RESET_PC is the first fetch; requests here are not yet meaningful.
          pc_valid <= 1'b1;
          state    <= RUN;
        end
        RUN: begin
          if (exc_valid) begin
            pc <= exc_pc;
          end else if (stall) begin
            if (bra_valid) begin
              pend_pc <= bra_pc;
              pending <= 1'b1;
              state   <= HOLD;
            end
          end else if (bra_valid) begin
            pc <= bra_pc;
          end else if (pred_valid) begin
            pc <= pred_pc;
          end else begin
            pc <= pc + ADDR_WIDTH'(INST_BYTES);
          end
        end
        HOLD: begin
          if (exc_valid) begin
            pc      <= exc_pc;
            pending <= 1'b0;
            state   <= RUN;
          end else if (stall) begin
            if (bra_valid) pend_pc <= bra_pc;
          end else begin
            // A fresh mispredict on the release edge is newer than the held one.
            pc      <= bra_valid ? bra_pc : pend_pc;
            pending <= 1'b0;
            state   <= RUN;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a spec-level model pushes expected
// pc/pc_valid/redirect_pending each cycle, popped after the clock edge.
module tb_pc_sequencer;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst, stall, exc_valid, bra_valid, pred_valid;
  logic [AW-1:0] exc_pc, bra_pc, pred_pc;
  logic [AW-1:0] pc;
  logic          pc_valid, flush_out, redirect_pending;

  pc_sequencer #(.ADDR_WIDTH(AW), .RESET_PC(32'hBFC00000), .INST_BYTES(4)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .exc_valid(exc_valid), .exc_pc(exc_pc),
    .bra_valid(bra_valid), .bra_pc(bra_pc),
    .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pc(pc), .pc_valid(pc_valid), .flush_out(flush_out),
    .redirect_pending(redirect_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] pc;
    logic          v;
    logic          p;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // model state: 0 boot, 1 run, 2 hold
  logic [AW-1:0] m_pc = 32'hBFC00000;
  logic [AW-1:0] m_pend_pc = '0;
  logic          m_v = 1'b0, m_p = 1'b0;
  int            m_st = 0;

  logic mon_en = 1'b0, seen_bad = 1'b0;
  always @(negedge clk) if (mon_en && pc === 32'h80002000) seen_bad = 1'b1;

  task automatic model_edge();
    if (rst) begin
      m_pc = 32'hBFC00000; m_v = 0; m_p = 0; m_pend_pc = '0; m_st = 0;
    end else if (m_st == 0) begin
      m_v = 1; m_st = 1;
    end else if (m_st == 1) begin
      if (exc_valid)       m_pc = exc_pc;
      else if (stall) begin
        if (bra_valid) begin m_pend_pc = bra_pc; m_p = 1; m_st = 2; end
      end
      else if (bra_valid)  m_pc = bra_pc;
      else if (pred_valid) m_pc = pred_pc;
      else                 m_pc = m_pc + 32'd4;
    end else begin
      if (exc_valid) begin m_pc = exc_pc; m_p = 0; m_st = 1; end
      else if (stall) begin
        if (bra_valid) m_pend_pc = bra_pc;
      end else begin
        m_pc = bra_valid ? bra_pc : m_pend_pc; m_p = 0; m_st = 1;
      end
    end
  endtask

  task automatic step(input logic r, input logic s,
                      input logic e, input logic [AW-1:0] ep,
                      input logic b, input logic [AW-1:0] bp,
                      input logic pv, input logic [AW-1:0] pp);
    exp_t x;
    @(negedge clk);
    rst = r; stall = s; exc_valid = e; exc_pc = ep;
    bra_valid = b; bra_pc = bp; pred_valid = pv; pred_pc = pp;
    #1;
    chk("flush_out", {31'd0, flush_out}, {31'd0, ~r & (e | b)});
    model_edge();
    x.pc = m_pc; x.v = m_v; x.p = m_p;
    q.push_back(x);
    @(posedge clk);
    #1;
    if (q.size() == 0) chk("sb_empty", 32'd0, 32'd1);
    else begin
      x = q.pop_front();
      chk("pc", pc, x.pc);
      chk("pc_valid", {31'd0, pc_valid}, {31'd0, x.v});
      chk("redirect_pending", {31'd0, redirect_pending}, {31'd0, x.p});
    end
  endtask

  task automatic idle(); step(0, 0, 0, 0, 0, 0, 0, 0); endtask

  initial begin
    rst = 1; stall = 0; exc_valid = 0; bra_valid = 0; pred_valid = 0;
    exc_pc = '0; bra_pc = '0; pred_pc = '0;

    // reset then idle
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("tp_reset_pc", pc, 32'hBFC00000);
    chk("tp_reset_valid", {31'd0, pc_valid}, 32'd0);
    idle();
    chk("tp_boot_valid", {31'd0, pc_valid}, 32'd1);
    chk("tp_boot_pc", pc, 32'hBFC00000);
    idle(); chk("tp_seq1", pc, 32'hBFC00004);
    idle(); chk("tp_seq2", pc, 32'hBFC00008);

    // prediction
    step(0, 0, 0, 0, 0, 0, 1, 32'hBFC00100); chk("tp_pred", pc, 32'hBFC00100);
    idle(); chk("tp_pred_seq", pc, 32'hBFC00104);

    // stalled mispredict
    step(0, 1, 0, 0, 1, 32'h80001000, 1, 32'h12345678);
    chk("tp_hold_pc", pc, 32'hBFC00104);
    chk("tp_hold_pend", {31'd0, redirect_pending}, 32'd1);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 32'h0000_4440);
    chk("tp_release_pc", pc, 32'h80001000);
    chk("tp_release_pend", {31'd0, redirect_pending}, 32'd0);

    // exception beats everything, from HOLD and from RUN
    step(0, 1, 0, 0, 1, 32'h80003000, 0, 0);
    step(0, 1, 1, 32'hBFC00380, 1, 32'h80004000, 1, 32'h55550000);
    chk("tp_exc_pc", pc, 32'hBFC00380);
    chk("tp_exc_pend", {31'd0, redirect_pending}, 32'd0);
    step(0, 1, 1, 32'hBFC00200, 0, 0, 0, 0);
    chk("tp_exc_run", pc, 32'hBFC00200);

    // latest mispredict wins; same-cycle branch on release wins over held target
    step(0, 1, 0, 0, 1, 32'h80005000, 0, 0);
    step(0, 1, 0, 0, 1, 32'h80006002, 0, 0);
    idle(); chk("tp_latest", pc, 32'h80006002);
    step(0, 1, 0, 0, 1, 32'h80007000, 0, 0);
    step(0, 0, 0, 0, 1, 32'h80008001, 0, 0); chk("tp_rel_bra", pc, 32'h80008001);

    // wrap-around
    step(0, 0, 0, 0, 1, 32'hFFFFFFFC, 0, 0);
    idle(); chk("tp_wrap", pc, 32'h00000000);

    // reset mid-hold: held target discarded, BOOT ignores requests
    mon_en = 1;
    step(0, 1, 0, 0, 1, 32'h80002000, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    chk("tp_rst_pc", pc, 32'hBFC00000);
    chk("tp_rst_pend", {31'd0, redirect_pending}, 32'd0);
    step(0, 0, 0, 0, 1, 32'h80009000, 0, 0);
    chk("tp_boot_ignore", pc, 32'hBFC00000);
    idle(); idle();
    mon_en = 0;
    chk("tp_never_pend", {31'd0, seen_bad}, 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(99) < 2), ($urandom_range(99) < 40),
           ($urandom_range(99) < 6), $urandom,
           ($urandom_range(99) < 20), $urandom,
           ($urandom_range(99) < 25), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC controller for the fetch front end; owns the fetch PC register that feeds the PC pipeline buffer stage.
- Arbitrates redirect sources: exception, branch-mispredict, predictor target, sequential PC+4.
- Holds the PC under stall.
- Keeps redirects that arrive during stall so none are lost.
- Drives the flush line of the downstream PC buffer stage.

Parameters:
- ADDR_WIDTH, 32, width of all PC/target buses.
- RESET_PC, 32'hBFC00000, first fetch address after reset.
- INST_BYTES, 4, sequential increment.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- stall  in  1  fetch stage stalled; hold PC.
- exc_valid  in  1  exception/ERET redirect request.
- exc_pc  in  ADDR_WIDTH  exception redirect target.
- bra_valid  in  1  branch-mispredict redirect request.
- bra_pc  in  ADDR_WIDTH  corrected branch target.
- pred_valid  in  1  predictor says current PC is predicted taken.
- pred_pc  in  ADDR_WIDTH  predicted target for current PC.
- pc  out  ADDR_WIDTH  current fetch PC.
- pc_valid  out  1  pc is a real fetch request.
- flush_out  out  1  flush to downstream PC buffer stage.
- redirect_pending  out  1  a stalled redirect is being held.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: pc=RESET_PC, pc_valid=0, pending=0, pend_pc=0, pend_is_exc=0, state=BOOT. flush_out follows its combinational equation; it is 0 during reset and 0 whenever exc_valid=0 and bra_valid=0. redirect_pending reflects pending, so it is 0.
- States:
  - BOOT: one cycle after rst falls. pc_valid<=1, pc unchanged (RESET_PC is fetched first). Next state RUN.
  - RUN: pending=0.
  - HOLD: pending=1.
- Inputs arriving in BOOT are ignored; no redirect is accepted before the first fetch.
- Next-PC priority in RUN, evaluated each edge:
  1. exc_valid: pc<=exc_pc, even if stall=1. The exception overrides the stall.
  2. stall=1: pc held. If bra_valid, capture pend_pc<=bra_pc, pending<=1, go to HOLD.
  3. bra_valid: pc<=bra_pc.
  4. pred_valid: pc<=pred_pc.
  5. Otherwise: pc<=pc+INST_BYTES, modulo 2^ADDR_WIDTH (wrap, no error).
- HOLD:
  - exc_valid: pc<=exc_pc, pending cleared, go to RUN. The exception supersedes the held branch.
  - stall=1 and bra_valid: pend_pc<=bra_pc. The latest mispredict wins; stay in HOLD.
  - stall=0: pc<=pend_pc, pending<=0, go to RUN. A same-cycle bra_valid wins over pend_pc. pred_valid is ignored on this edge.
- Latency: redirects are visible on pc one cycle after the request edge (pending case: one cycle after stall falls).
- flush_out = exc_valid | bra_valid, combinational and unregistered. It is also asserted while stalled, so the downstream buffer drops its wrong-path PC.
- pred_valid/pred_pc while stall=1 are ignored; the predictor re-evaluates on the held PC.
- Target bits [1:0] pass through unaltered. Alignment faults are detected downstream.
- pc_valid stays 1 after BOOT until the next rst.
- rst asserted in any state returns all state to reset values on that edge, including a held redirect, which is discarded.
- pend_is_exc is reserved for internal use; it is always 0 since exceptions are never held.

Test Plan:
- Reset then idle: rst 1 for 2 cycles, then 0, no requests.
  - Required: pc=BFC00000 with pc_valid=0, then 1.
  - Then pc=BFC00004, BFC00008 on successive cycles.
- Prediction: at pc=BFC00008 drive pred_valid=1, pred_pc=BFC00100.
  - Required: next pc=BFC00100, then BFC00104; flush_out stays 0.
- Stalled mispredict: stall=1 for 3 cycles; bra_valid=1, bra_pc=80001000 on the first stall cycle.
  - Required: flush_out=1 that cycle, redirect_pending=1, pc held.
  - Required: the cycle after stall falls, pc=80001000 and redirect_pending=0.
- Exception beats everything:
  - Drive exc_valid=1, exc_pc=BFC00380 with bra_valid=1, pred_valid=1, stall=1 all together.
  - Required: next pc=BFC00380, flush_out=1. If in HOLD beforehand, redirect_pending clears.
- Wrap-around: force pc=FFFFFFFC via bra_pc.
  - Required: next sequential pc=00000000 with no stall.
- Reset mid-hold: in HOLD with pend_pc=80002000, assert rst for 1 cycle.
  - Required: pc=BFC00000, redirect_pending=0.
  - Required: 80002000 never appears on pc.
